timerio: RTL and testbench

- 16-bit programmable interval timer on the CPU bus at $E6B0–$E6B7, decoded by the top level as AD[15:3] == 13'b1110011010110.
- Provides an 8-bit prescaler, a 16-bit up-counter, a 16-bit compare register, auto-reload, and compare and overflow flags.
- Drives an IRQ line that the top level ORs into sys_irq alongside simpleio_irq.
- Register interface matches the other I/O blocks: AD[2:0], DI, DO, rw, cs, all sampled on the CPU clock.

---
 rtl/timerio.sv | 138 +++++++++++++
 tb/tb_timerio.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timerio.sv
// Bus-mapped 16-bit interval timer with an 8-bit prescaler, compare/reload and overflow flags.
// Register map at AD[2:0]; DO is a pure function of AD and register state.
module timerio #(
  parameter logic [15:0] CMP_INIT   = 16'hFFFF,
  parameter logic [7:0]  PRESC_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       b_reset,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq
);

  localparam logic [2:0] ADDR_CTRL  = 3'd0;
  localparam logic [2:0] ADDR_STAT  = 3'd1;
  localparam logic [2:0] ADDR_CNT_H = 3'd2;
  localparam logic [2:0] ADDR_CNT_L = 3'd3;
  localparam logic [2:0] ADDR_CMP_H = 3'd4;
  localparam logic [2:0] ADDR_CMP_L = 3'd5;
  localparam logic [2:0] ADDR_PRESC = 3'd6;

  logic [3:0]  ctrl_q, ctrl_d;
  logic        cmpf_q, cmpf_d;
  logic        ovf_q, ovf_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cmp_q, cmp_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [7:0]  wrbuf_q, wrbuf_d;
  logic [7:0]  rdlatch_q, rdlatch_d;

  logic        en, cmpie, ovfie, reload;
  logic        wr_en, rd_cnt_h, cnt_load, stat_wr;
  logic        pcnt_match, tick, cmp_hit, ovf_hit;
  logic [15:0] cnt_inc;

  assign en     = ctrl_q[0];
  assign cmpie  = ctrl_q[1];
  assign ovfie  = ctrl_q[2];
  assign reload = ctrl_q[3];

  always_comb begin
    wr_en      = cs && !rw;
    rd_cnt_h   = cs && rw && (AD == ADDR_CNT_H);
    cnt_load   = wr_en && (AD == ADDR_CNT_L);
    stat_wr    = wr_en && (AD == ADDR_STAT);
    pcnt_match = (pcnt_q == presc_q);
    // A CNT_L load owns the counter this cycle, so the tick is swallowed.
    tick       = en && pcnt_match && !cnt_load;
    cmp_hit    = tick && (cnt_q == cmp_q);
    // Overflow is skipped only when a compare hit at FFFF reloads to zero.
    ovf_hit    = tick && (cnt_q == 16'hFFFF) && !(cmp_hit && reload);
    cnt_inc    = cnt_q + 16'd1;
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    cmp_d     = cmp_q;
    presc_d   = presc_q;
    wrbuf_d   = wrbuf_q;
    rdlatch_d = rdlatch_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q + 8'd1;

    if (!en || cnt_load || pcnt_match) begin
      pcnt_d = 8'd0;
    end

    if (rd_cnt_h) begin
      rdlatch_d = cnt_q[7:0];
    end

    if (wr_en) begin
      case (AD)
        ADDR_CTRL:  ctrl_d  = DI[3:0];
        ADDR_CNT_H: wrbuf_d = DI;
        ADDR_CMP_H: wrbuf_d = DI;
        ADDR_CMP_L: cmp_d   = {wrbuf_q, DI};
        ADDR_PRESC: presc_d = DI;
        default: ;
      endcase
    end

    if (cnt_load) begin
      cnt_d = {wrbuf_q, DI};
    end else if (tick) begin
      cnt_d = (cmp_hit && reload) ? 16'd0 : cnt_inc;
    end

    // Set events take priority over write-1-to-clear.
    cmpf_d = (cmpf_q && !(stat_wr && DI[0])) || cmp_hit;
    ovf_d  = (ovf_q && !(stat_wr && DI[1])) || ovf_hit;
  end

  always_ff @(posedge clk or negedge b_reset) begin
    if (!b_reset) begin
      ctrl_q    <= 4'h0;
      cmpf_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= 16'h0000;
      cmp_q     <= CMP_INIT;
      presc_q   <= PRESC_INIT;
      pcnt_q    <= 8'h00;
      wrbuf_q   <= 8'h00;
      rdlatch_q <= 8'h00;
    end else begin
      ctrl_q    <= ctrl_d;
      cmpf_q    <= cmpf_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      wrbuf_q   <= wrbuf_d;
      rdlatch_q <= rdlatch_d;
    end
  end

  always_comb begin
    DO = 8'h00;
    case (AD)
      ADDR_CTRL:  DO = {4'h0, ctrl_q};
      ADDR_STAT:  DO = {6'h00, ovf_q, cmpf_q};
      ADDR_CNT_H: DO = cnt_q[15:8];
      ADDR_CNT_L: DO = rdlatch_q;
      ADDR_CMP_H: DO = cmp_q[15:8];
      ADDR_CMP_L: DO = cmp_q[7:0];
      ADDR_PRESC: DO = presc_q;
      default:    DO = 8'h00;
    endcase
  end

  assign irq = (cmpf_q && cmpie) || (ovf_q && ovfie);

endmodule

// File: tb/tb_timerio.sv
// Bench for timerio: directed scenarios with literal expectations plus random bus traffic,
// all continuously compared against a transaction-level model of the register file.
module tb_timerio;

  logic       clk;
  logic       b_reset;
  logic [2:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       irq;

  int checks = 0;
  int errors = 0;

  timerio #(
    .CMP_INIT  (16'hFFFF),
    .PRESC_INIT(8'h00)
  ) dut (
    .clk    (clk),
    .b_reset(b_reset),
    .AD     (AD),
    .DI     (DI),
    .DO     (DO),
    .rw     (rw),
    .cs     (cs),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic        cmpf;
    logic        ovf;
    logic [15:0] cnt;
    logic [15:0] cmp;
    logic [7:0]  presc;
    logic [7:0]  pcnt;
    logic [7:0]  wrbuf;
    logic [7:0]  rdl;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t m_reset();
    mstate_t r;
    r = '0;
    r.cmp = 16'hFFFF;
    return r;
  endfunction

  // One bus cycle of the timer as software sees it.
  function automatic mstate_t m_step(mstate_t s, logic c, logic r, logic [2:0] a, logic [7:0] d);
    mstate_t n;
    logic wr, load, tick;
    n    = s;
    wr   = c && !r;
    load = wr && (a == 3'd3);
    tick = 1'b0;
    if (!s.ctrl[0] || load) n.pcnt = 8'd0;
    else if (s.pcnt == s.presc) begin
      tick   = 1'b1;
      n.pcnt = 8'd0;
    end else n.pcnt = s.pcnt + 8'd1;
    if (c && r && a == 3'd2) n.rdl = s.cnt[7:0];
    if (wr) begin
      case (a)
        3'd0: n.ctrl = d[3:0];
        3'd1: begin
          if (d[0]) n.cmpf = 1'b0;
          if (d[1]) n.ovf = 1'b0;
        end
        3'd2, 3'd4: n.wrbuf = d;
        3'd3: n.cnt = {s.wrbuf, d};
        3'd5: n.cmp = {s.wrbuf, d};
        3'd6: n.presc = d;
        default: ;
      endcase
    end
    if (tick) begin
      if (s.cnt == s.cmp) begin
        n.cmpf = 1'b1;
        if (s.ctrl[3]) n.cnt = 16'd0;
        else begin
          n.cnt = s.cnt + 16'd1;
          if (s.cnt == 16'hFFFF) n.ovf = 1'b1;
        end
      end else if (s.cnt == 16'hFFFF) begin
        n.ovf = 1'b1;
        n.cnt = 16'd0;
      end else n.cnt = s.cnt + 16'd1;
    end
    return n;
  endfunction

  function automatic logic [7:0] m_read(mstate_t s, logic [2:0] a);
    case (a)
      3'd0: return {4'h0, s.ctrl};
      3'd1: return {6'h00, s.ovf, s.cmpf};
      3'd2: return s.cnt[15:8];
      3'd3: return s.rdl;
      3'd4: return s.cmp[15:8];
      3'd5: return s.cmp[7:0];
      3'd6: return s.presc;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic m_irq(mstate_t s);
    return (s.cmpf && s.ctrl[1]) || (s.ovf && s.ctrl[2]);
  endfunction

  always @(posedge clk or negedge b_reset) begin
    if (!b_reset) m <= m_reset();
    else m <= m_step(m, cs, rw, AD, DI);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (b_reset) begin
      check("model_do", {8'h00, DO}, {8'h00, m_read(m, AD)});
      check("model_irq", {15'h0, irq}, {15'h0, m_irq(m)});
    end
  end

  // Both bus tasks are entered 1ns after a rising edge and return 1ns after the next one.
  task automatic wr(input logic [2:0] a, input logic [7:0] v);
    cs = 1'b1;
    rw = 1'b0;
    AD = a;
    DI = v;
    @(posedge clk);
    #1;
    cs = 1'b0;
    rw = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1;
    rw = 1'b1;
    AD = a;
    @(negedge clk);
    d = DO;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  logic [7:0] rd_val;
  logic [7:0] rst_exp [8];

  initial begin
    rst_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
    b_reset = 1'b0;
    cs = 1'b0;
    rw = 1'b1;
    AD = 3'd0;
    DI = 8'h00;
    repeat (2) @(posedge clk);
    #3 b_reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of counting with a pending interrupt.
    wr(3'd4, 8'h00);
    wr(3'd5, 8'h02);
    wr(3'd0, 8'h03);
    repeat (5) @(posedge clk);
    #1;
    check("irq_before_reset", {15'h0, irq}, 16'h0001);
    #3 b_reset = 1'b0;
    #1;
    check("irq_async_reset", {15'h0, irq}, 16'h0000);
    #3 b_reset = 1'b1;
    @(posedge clk);
    #1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), rd_val);
      check($sformatf("reset_read_%0d", a), {8'h00, rd_val}, {8'h00, rst_exp[a]});
    end

    // Prescale 3 with reload at compare 4: five ticks of four clocks each.
    wr(3'd6, 8'h03);
    wr(3'd4, 8'h00);
    wr(3'd5, 8'h04);
    wr(3'd0, 8'h0B);
    repeat (19) @(posedge clk);
    #1;
    check("reload_irq_19", {15'h0, irq}, 16'h0000);
    @(posedge clk);
    #1;
    check("reload_irq_20", {15'h0, irq}, 16'h0001);
    rd(3'd2, rd_val);
    check("reload_cnt_h", {8'h00, rd_val}, 16'h0000);
    rd(3'd3, rd_val);
    check("reload_cnt_l", {8'h00, rd_val}, 16'h0000);
    wr(3'd1, 8'h01);
    repeat (16) @(posedge clk);
    #1;
    check("reload_irq_39", {15'h0, irq}, 16'h0000);
    @(posedge clk);
    #1;
    check("reload_irq_40", {15'h0, irq}, 16'h0001);

    // Overflow from FFFE at full speed.
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h03);
    wr(3'd6, 8'h00);
    wr(3'd2, 8'hFF);
    wr(3'd3, 8'hFE);
    wr(3'd4, 8'h12);
    wr(3'd5, 8'h34);
    wr(3'd0, 8'h05);
    repeat (2) @(posedge clk);
    #1;
    check("ovf_irq", {15'h0, irq}, 16'h0001);
    rd(3'd2, rd_val);
    check("ovf_cnt_h", {8'h00, rd_val}, 16'h0000);
    rd(3'd3, rd_val);
    check("ovf_cnt_l", {8'h00, rd_val}, 16'h0000);
    rd(3'd1, rd_val);
    check("ovf_stat", {8'h00, rd_val}, 16'h0002);
    wr(3'd1, 8'h02);
    check("ovf_irq_cleared", {15'h0, irq}, 16'h0000);

    // Counter read is atomic across the byte boundary.
    wr(3'd0, 8'h00);
    wr(3'd2, 8'h00);
    wr(3'd3, 8'hFF);
    wr(3'd0, 8'h01);
    rd(3'd2, rd_val);
    check("atomic_hi", {8'h00, rd_val}, 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    rd(3'd3, rd_val);
    check("atomic_lo", {8'h00, rd_val}, 16'h00FF);

    // Clear of CMPF on the very edge a compare sets it.
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h03);
    wr(3'd2, 8'h00);
    wr(3'd3, 8'h00);
    wr(3'd4, 8'h00);
    wr(3'd5, 8'h03);
    wr(3'd0, 8'h03);
    repeat (3) @(posedge clk);
    #1;
    wr(3'd1, 8'h01);
    rd(3'd1, rd_val);
    check("set_beats_clear", {8'h00, rd_val}, 16'h0001);
    check("set_beats_clear_irq", {15'h0, irq}, 16'h0001);

    // CNT_L load while ticking every clock: no increment on the load edge.
    wr(3'd2, 8'h50);
    wr(3'd3, 8'h60);
    rd(3'd2, rd_val);
    check("load_no_tick_hi", {8'h00, rd_val}, 16'h0050);
    rd(3'd3, rd_val);
    check("load_no_tick_lo", {8'h00, rd_val}, 16'h0060);

    // Freeze at 0x0010, then resume with prescale 1.
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h03);
    wr(3'd2, 8'h00);
    wr(3'd3, 8'h0E);
    wr(3'd6, 8'h00);
    wr(3'd0, 8'h01);
    @(posedge clk);
    #1;
    wr(3'd0, 8'h00);
    repeat (50) @(posedge clk);
    #1;
    rd(3'd2, rd_val);
    check("freeze_hi", {8'h00, rd_val}, 16'h0000);
    rd(3'd3, rd_val);
    check("freeze_lo", {8'h00, rd_val}, 16'h0010);
    wr(3'd6, 8'h01);
    wr(3'd0, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    rd(3'd2, rd_val);
    check("resume_hi", {8'h00, rd_val}, 16'h0000);
    rd(3'd3, rd_val);
    check("resume_lo", {8'h00, rd_val}, 16'h0011);

    // Random bus traffic; small prescaler values keep the counter busy.
    for (int i = 0; i < 3000; i++) begin
      int unsigned op;
      op = $urandom_range(0, 7);
      AD = 3'($urandom_range(0, 7));
      DI = 8'($urandom);
      cs = (op != 0);
      rw = (op >= 4);
      if (AD == 3'd6 && !rw) DI = 8'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    cs = 1'b0;
    rw = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
